// File: rtl/pixel_write_scheduler_pkg.sv
// Shared constants and FSM encoding for the pixel-write scheduler and its arbiter.
package pixel_sched_defs;

    localparam int NUM_REQ  = 4;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    // Index width that stays legal for a single-client build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_write_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module rr_arbiter
    import pixel_sched_defs::*;
#(
    parameter int NUM_REQ = pixel_sched_defs::NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_pointer,
    output logic [NUM_REQ-1:0] o_winner,
    output logic [IDX_W-1:0]   o_winner_idx,
    output logic               o_valid
);

    logic [IDX_W:0] w_cand [NUM_REQ];

    // Candidate gi is the client gi positions after the pointer, modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] w_raw;
        assign w_raw       = {1'b0, i_pointer} + (IDX_W+1)'(gi);
        assign w_cand[gi]  = (w_raw >= (IDX_W+1)'(NUM_REQ)) ? w_raw - (IDX_W+1)'(NUM_REQ) : w_raw;
    end

    always_comb begin
        o_winner_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k][IDX_W-1:0]]) begin
                o_winner_idx = w_cand[k][IDX_W-1:0];
            end
        end
    end

    assign o_valid  = |i_req;
    assign o_winner = o_valid ? (NUM_REQ'(1) << o_winner_idx) : '0;

endmodule

// File: rtl/pixel_write_scheduler.sv
// Shares one vga_adapter pixel port between NUM_REQ rectangle-fill clients,
// sweeping each granted rectangle at one pixel per clock with screen clipping.
module pixel_write_scheduler
    import pixel_sched_defs::*;
#(
    parameter int NUM_REQ  = pixel_sched_defs::NUM_REQ,
    parameter int X_W      = pixel_sched_defs::X_W,
    parameter int Y_W      = pixel_sched_defs::Y_W,
    parameter int COLOUR_W = pixel_sched_defs::COLOUR_W,
    parameter int SCREEN_W = pixel_sched_defs::SCREEN_W,
    parameter int SCREEN_H = pixel_sched_defs::SCREEN_H
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*X_W-1:0]      req_x0,
    input  logic [NUM_REQ*Y_W-1:0]      req_y0,
    input  logic [NUM_REQ*X_W-1:0]      req_w,
    input  logic [NUM_REQ*Y_W-1:0]      req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic [X_W-1:0]              x,
    output logic [Y_W-1:0]              y,
    output logic [COLOUR_W-1:0]         colour,
    output logic                        writeEn
);

    localparam int                IDX_W    = idx_width(NUM_REQ);
    localparam logic [X_W-1:0]    X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]    Y_ONE    = Y_W'(1);
    localparam logic [X_W:0]      X_LIMIT  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]      Y_LIMIT  = (Y_W+1)'(SCREEN_H);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    sched_state_t         r_state, w_state_next;
    logic [NUM_REQ-1:0]   r_grant, w_arb_onehot;
    logic [IDX_W-1:0]     r_rr_ptr, r_win_idx, w_arb_idx;
    logic                 w_arb_valid;

    logic [X_W-1:0]       r_x0, r_w, r_cx, r_x;
    logic [Y_W-1:0]       r_y0, r_h, r_cy, r_y;
    logic [COLOUR_W-1:0]  r_fill, r_colour;
    logic                 r_we;

    logic [X_W-1:0]       w_sel_x0, w_sel_w, w_pix_x0, w_pix_cx;
    logic [Y_W-1:0]       w_sel_y0, w_sel_h, w_pix_y0, w_pix_cy;
    logic [COLOUR_W-1:0]  w_sel_colour, w_pix_colour;
    logic [X_W:0]         w_sum_x;
    logic [Y_W:0]         w_sum_y;
    logic                 w_on_screen, w_last_col, w_last_row;
    logic                 w_take_grant, w_latch, w_emit, w_finish;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req        (req),
        .i_pointer    (r_rr_ptr),
        .o_winner     (w_arb_onehot),
        .o_winner_idx (w_arb_idx),
        .o_valid      (w_arb_valid)
    );

    assign w_sel_x0     = req_x0[r_win_idx*X_W +: X_W];
    assign w_sel_y0     = req_y0[r_win_idx*Y_W +: Y_W];
    assign w_sel_w      = req_w[r_win_idx*X_W +: X_W];
    assign w_sel_h      = req_h[r_win_idx*Y_W +: Y_W];
    assign w_sel_colour = req_colour[r_win_idx*COLOUR_W +: COLOUR_W];

    // The pixel registered at the end of ARB is (0,0) of the incoming rectangle;
    // in DRAW it is the successor of the pixel currently on the outputs.
    always_comb begin
        w_last_col = (r_cx == r_w - X_ONE);
        w_last_row = (r_cy == r_h - Y_ONE);
        if (r_state == ST_ARB) begin
            w_pix_x0     = w_sel_x0;
            w_pix_y0     = w_sel_y0;
            w_pix_cx     = '0;
            w_pix_cy     = '0;
            w_pix_colour = w_sel_colour;
        end else begin
            w_pix_x0     = r_x0;
            w_pix_y0     = r_y0;
            w_pix_cx     = w_last_col ? '0 : r_cx + X_ONE;
            w_pix_cy     = w_last_col ? r_cy + Y_ONE : r_cy;
            w_pix_colour = r_fill;
        end
    end

    assign w_sum_x     = {1'b0, w_pix_x0} + {1'b0, w_pix_cx};
    assign w_sum_y     = {1'b0, w_pix_y0} + {1'b0, w_pix_cy};
    assign w_on_screen = (w_sum_x < X_LIMIT) && (w_sum_y < Y_LIMIT);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_take_grant = 1'b0;
        w_latch      = 1'b0;
        w_emit       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_take_grant = 1'b1;
                    w_state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                w_latch = 1'b1;
                if (w_sel_w == '0 || w_sel_h == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_emit       = 1'b1;
                    w_state_next = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (w_last_col && w_last_row) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_emit = 1'b1;
                end
            end
            ST_DONE: begin
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_win_idx <= '0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_fill    <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_we      <= 1'b0;
        end else begin
            if (w_take_grant) begin
                r_grant   <= w_arb_onehot;
                r_win_idx <= w_arb_idx;
            end
            if (w_latch) begin
                r_x0   <= w_sel_x0;
                r_y0   <= w_sel_y0;
                r_w    <= w_sel_w;
                r_h    <= w_sel_h;
                r_fill <= w_sel_colour;
                r_cx   <= '0;
                r_cy   <= '0;
            end
            if (w_emit) begin
                r_cx     <= w_pix_cx;
                r_cy     <= w_pix_cy;
                r_x      <= w_sum_x[X_W-1:0];
                r_y      <= w_sum_y[Y_W-1:0];
                r_colour <= w_pix_colour;
            end
            r_we <= w_emit && w_on_screen;
            if (w_finish) begin
                r_grant  <= '0;
                r_rr_ptr <= (r_win_idx == IDX_LAST) ? '0 : r_win_idx + IDX_ONE;
            end
        end
    end

    assign grant   = r_grant;
    assign done    = (r_state == ST_DONE) ? r_grant : '0;
    assign busy    = (r_state != ST_IDLE);
    assign x       = r_x;
    assign y       = r_y;
    assign colour  = r_colour;
    assign writeEn = r_we;

endmodule
